// File: rtl/gate_bist_pkg.sv
// Shared constants for the gate self-test engine: FSM encoding, gate bit positions
// and the error-counter ceiling.
package gate_bist_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int unsigned GATE_AND  = 0;
    localparam int unsigned GATE_OR   = 1;
    localparam int unsigned GATE_NOT  = 2;
    localparam int unsigned GATE_NAND = 3;
    localparam int unsigned GATE_NOR  = 4;
    localparam int unsigned GATE_XOR  = 5;
    localparam int unsigned GATE_XNOR = 6;
    localparam int unsigned NUM_GATES = 7;

    localparam int unsigned ERR_CNT_MAX = 255;

    function automatic logic [3:0] popcount7(input logic [NUM_GATES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus/response bundle between the self-test engine and the gate block.
interface gate_bist_if;
    logic in1;
    logic in2;
    logic outand;
    logic outor;
    logic outnot;
    logic outnand;
    logic outnor;
    logic outxor;
    logic outxnor;

    modport master (
        output in1, in2,
        input  outand, outor, outnot, outnand, outnor, outxor, outxnor
    );

    modport slave (
        input  in1, in2,
        output outand, outor, outnot, outnand, outnor, outxor, outxnor
    );
endinterface

// File: rtl/gate_bist_gate_ref_model.sv
// Golden two-input gate responses, packed in err_mask bit order.
module gate_ref_model
    import gate_bist_pkg::*;
(
    input  logic                 in1,
    input  logic                 in2,
    output logic [NUM_GATES-1:0] exp
);

    always_comb begin
        exp            = '0;
        exp[GATE_AND]  = in1 & in2;
        exp[GATE_OR]   = in1 | in2;
        exp[GATE_NOT]  = ~in1;
        exp[GATE_NAND] = ~(in1 & in2);
        exp[GATE_NOR]  = ~(in1 | in2);
        exp[GATE_XOR]  = in1 ^ in2;
        exp[GATE_XNOR] = ~(in1 ^ in2);
    end

endmodule

// File: rtl/gate_bist.sv
// Truth-table sweep engine: drives all four input vectors into the gate block,
// checks the seven responses against the reference model and accumulates results.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned REPEAT        = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    gate_bist_if.master   gate,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [6:0]    err_mask,
    output logic [7:0]    err_count,
    output logic [1:0]    first_fail
);

    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [7:0] SWEEP_LAST  = 8'(REPEAT - 1);

    logic [2:0]           state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [7:0]           sweep_q, sweep_d;
    logic [3:0]           settle_q, settle_d;
    logic                 in1_q, in1_d, in2_q, in2_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [6:0]           err_mask_q, err_mask_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [1:0]           first_fail_q, first_fail_d;

    logic [NUM_GATES-1:0] exp_resp;
    logic [NUM_GATES-1:0] sampled;
    logic [NUM_GATES-1:0] mismatch;
    logic [8:0]           cnt_sum;

    gate_ref_model u_ref (
        .in1 (in1_q),
        .in2 (in2_q),
        .exp (exp_resp)
    );

    always_comb begin
        sampled            = '0;
        sampled[GATE_AND]  = gate.outand;
        sampled[GATE_OR]   = gate.outor;
        sampled[GATE_NOT]  = gate.outnot;
        sampled[GATE_NAND] = gate.outnand;
        sampled[GATE_NOR]  = gate.outnor;
        sampled[GATE_XOR]  = gate.outxor;
        sampled[GATE_XNOR] = gate.outxnor;
    end

    assign mismatch = exp_resp ^ sampled;
    assign cnt_sum  = {1'b0, err_count_q} + 9'(popcount7(mismatch));

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        sweep_d      = sweep_q;
        settle_d     = settle_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_mask_d   = err_mask_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_mask_d   = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    vec_d        = '0;
                    sweep_d      = '0;
                    in1_d        = 1'b0;
                    in2_d        = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                in1_d    = vec_q[1];
                in2_d    = vec_q[0];
                settle_d = SETTLE_LOAD;
                state_d  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CHECK: begin
                err_mask_d  = err_mask_q | mismatch;
                err_count_d = (cnt_sum > 9'(ERR_CNT_MAX)) ? 8'(ERR_CNT_MAX) : cnt_sum[7:0];
                // err_mask is cleared at start, so an all-zero mask means no earlier failure
                if ((err_mask_q == '0) && (mismatch != '0)) begin
                    first_fail_d = {in1_q, in2_q};
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = ST_APPLY;
                end else if (sweep_q < SWEEP_LAST) begin
                    vec_d   = 2'd0;
                    sweep_d = sweep_q + 8'd1;
                    state_d = ST_APPLY;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            sweep_q      <= '0;
            settle_q     <= '0;
            in1_q        <= 1'b0;
            in2_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_mask_q   <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            sweep_q      <= sweep_d;
            settle_q     <= settle_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_mask_q   <= err_mask_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign gate.in1   = in1_q;
    assign gate.in2   = in2_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = done_q && (err_mask_q == '0);
    assign err_mask   = err_mask_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: four engine instances with different settle/repeat settings, each
// driving a gate block model with a selectable fault.
module tb_gate_bist;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] start_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] pass_v;
    logic [1:0] fault_v [4];
    logic [6:0] mask_v  [4];
    logic [7:0] cnt_v   [4];
    logic [1:0] ff_v    [4];

    int total = 0;
    int bad   = 0;

    // Gate block stand-in. fault: 0 good, 1 xor stuck-at-0, 2 not driven by ~in2, 3 all inverted
    function automatic logic [6:0] gate_resp(input logic [1:0] fault, input logic a, input logic b);
        logic [6:0] r;
        r = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        case (fault)
            2'd1:    r[5] = 1'b0;
            2'd2:    r[2] = ~b;
            2'd3:    r = ~r;
            default: ;
        endcase
        return r;
    endfunction

    gate_bist_if g0 ();
    gate_bist_if g1 ();
    gate_bist_if g2 ();
    gate_bist_if g3 ();

    assign {g0.outxnor, g0.outxor, g0.outnor, g0.outnand, g0.outnot, g0.outor, g0.outand} =
        gate_resp(fault_v[0], g0.in1, g0.in2);
    assign {g1.outxnor, g1.outxor, g1.outnor, g1.outnand, g1.outnot, g1.outor, g1.outand} =
        gate_resp(fault_v[1], g1.in1, g1.in2);
    assign {g2.outxnor, g2.outxor, g2.outnor, g2.outnand, g2.outnot, g2.outor, g2.outand} =
        gate_resp(fault_v[2], g2.in1, g2.in2);
    assign {g3.outxnor, g3.outxor, g3.outnor, g3.outnand, g3.outnot, g3.outor, g3.outand} =
        gate_resp(fault_v[3], g3.in1, g3.in2);

    gate_bist #(.SETTLE_CYCLES(2), .REPEAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .gate(g0), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_mask(mask_v[0]), .err_count(cnt_v[0]), .first_fail(ff_v[0])
    );
    gate_bist #(.SETTLE_CYCLES(2), .REPEAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .gate(g1), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_mask(mask_v[1]), .err_count(cnt_v[1]), .first_fail(ff_v[1])
    );
    gate_bist #(.SETTLE_CYCLES(2), .REPEAT(40)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .gate(g2), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_mask(mask_v[2]), .err_count(cnt_v[2]), .first_fail(ff_v[2])
    );
    gate_bist #(.SETTLE_CYCLES(0), .REPEAT(1)) dut3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .gate(g3), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .err_mask(mask_v[3]), .err_count(cnt_v[3]), .first_fail(ff_v[3])
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Start a run on instance sel and count cycles from the start-sampling edge to done.
    task automatic run(input int sel, input logic [1:0] fault, input int pulse, output int lat);
        fault_v[sel] = fault;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        chk($sformatf("busy_after_start[%0d]", sel), int'(busy_v[sel]), 1);
        chk($sformatf("done_after_start[%0d]", sel), int'(done_v[sel]), 0);
        lat = 0;
        while (!done_v[sel] && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            start_v[sel] = (lat == pulse);
        end
        start_v[sel] = 1'b0;
    endtask

    typedef struct {
        int         sel;
        logic [1:0] fault;
        int         pulse;
        logic [6:0] mask;
        int         cnt;
        logic [1:0] ff;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int lat;

        tbl[0] = '{0, 2'd0, 5,  7'h00,        0,   2'b00, 1'b1, 16};
        tbl[1] = '{0, 2'd1, -1, 7'b0100000,   2,   2'b01, 1'b0, 16};
        tbl[2] = '{1, 2'd2, -1, 7'b0000100,   6,   2'b01, 1'b0, 48};
        tbl[3] = '{2, 2'd3, -1, 7'h7F,        255, 2'b00, 1'b0, 640};
        tbl[4] = '{3, 2'd0, -1, 7'h00,        0,   2'b00, 1'b1, 8};
        tbl[5] = '{0, 2'd3, -1, 7'h7F,        28,  2'b00, 1'b0, 16};
        tbl[6] = '{3, 2'd1, -1, 7'b0100000,   2,   2'b01, 1'b0, 8};

        rst     = 1'b1;
        start_v = '0;
        for (int i = 0; i < 4; i++) fault_v[i] = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_pass", int'(pass_v[0]), 0);
        chk("rst_mask", int'(mask_v[0]), 0);
        chk("rst_cnt",  int'(cnt_v[0]), 0);
        chk("rst_ff",   int'(ff_v[0]), 0);
        chk("rst_vec",  int'({g0.in1, g0.in2}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].sel, tbl[i].fault, tbl[i].pulse, lat);
            chk($sformatf("t%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("t%0d_mask", i), int'(mask_v[tbl[i].sel]), int'(tbl[i].mask));
            chk($sformatf("t%0d_count", i), int'(cnt_v[tbl[i].sel]), tbl[i].cnt);
            chk($sformatf("t%0d_first_fail", i), int'(ff_v[tbl[i].sel]), int'(tbl[i].ff));
            chk($sformatf("t%0d_pass", i), int'(pass_v[tbl[i].sel]), int'(tbl[i].pass));
            chk($sformatf("t%0d_busy_end", i), int'(busy_v[tbl[i].sel]), 0);
        end

        // Vector trace on a clean restart from DONE: each vector lands at edge 4k+1.
        fault_v[0] = 2'd0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 2)  chk("trace_vec00", int'({g0.in1, g0.in2}), 0);
            if (c == 6)  chk("trace_vec01", int'({g0.in1, g0.in2}), 1);
            if (c == 10) chk("trace_vec10", int'({g0.in1, g0.in2}), 2);
            if (c == 14) chk("trace_vec11", int'({g0.in1, g0.in2}), 3);
            if (c == 15) chk("trace_not_done_15", int'(done_v[0]), 0);
            if (c == 16) chk("trace_done_16", int'(done_v[0]), 1);
        end
        chk("hold_vec_in_done", int'({g0.in1, g0.in2}), 3);
        chk("hold_done", int'(done_v[0]), 1);
        chk("hold_pass", int'(pass_v[0]), 1);

        // Reset while settling on vector 10, after the 01 mismatch has been counted.
        fault_v[0] = 2'd1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_vec", int'({g0.in1, g0.in2}), 2);
        chk("pre_rst_cnt", int'(cnt_v[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_done", int'(done_v[0]), 0);
        chk("abort_pass", int'(pass_v[0]), 0);
        chk("abort_mask", int'(mask_v[0]), 0);
        chk("abort_cnt",  int'(cnt_v[0]), 0);
        chk("abort_ff",   int'(ff_v[0]), 0);
        chk("abort_vec",  int'({g0.in1, g0.in2}), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_stays_quiet", int'(busy_v[0]), 0);

        run(0, 2'd0, -1, lat);
        chk("post_rst_latency", lat, 16);
        chk("post_rst_mask", int'(mask_v[0]), 0);
        chk("post_rst_cnt", int'(cnt_v[0]), 0);
        chk("post_rst_pass", int'(pass_v[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
